// File: rtl/phy_tx_interleaver.sv
// 802.11a transmit block interleaver: serial coded bits in, permuted symbol out.
// Two symbol banks in ping-pong so one symbol is written while the other drains.
module phy_tx_interleaver #(
   parameter int unsigned MAX_NCBPS = 288,
   parameter int unsigned ADDR_W    = 9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       inputData,
   input  logic       TX_IN_VALID,
   output logic       TX_IN_READY,
   input  logic [1:0] MOD_SEL,
   output logic       TX_OUT,
   output logic       TX_OUT_VALID,
   output logic       SYM_DONE
);

   function automatic logic [ADDR_W-1:0] ncbps_of(input logic [1:0] m);
      unique case (m)
         2'b00:   return ADDR_W'(48);
         2'b01:   return ADDR_W'(96);
         2'b10:   return ADDR_W'(192);
         default: return ADDR_W'(288);
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] n16_of(input logic [1:0] m);
      unique case (m)
         2'b00:   return ADDR_W'(3);
         2'b01:   return ADDR_W'(6);
         2'b10:   return ADDR_W'(12);
         default: return ADDR_W'(18);
      endcase
   endfunction

   function automatic logic [1:0] s_of(input logic [1:0] m);
      unique case (m)
         2'b00:   return 2'd1;
         2'b01:   return 2'd1;
         2'b10:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   // Write side: k = 16*row + col; idx tracks i = (N/16)*col + row.
   logic [3:0]        col_q;
   logic [ADDR_W-1:0] row_q;
   logic [ADDR_W-1:0] idx_q;
   logic [1:0]        rm_q;    // row mod s (equals i mod s since s divides N/16)
   logic [1:0]        cm_q;    // col mod s
   logic [1:0]        mod_q;
   logic              wr_ptr_q;

   // Read side and bank bookkeeping.
   logic              rd_ptr_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [1:0]        full_q;
   logic [1:0]        bank_mod_q [2];
   logic [MAX_NCBPS-1:0] bank_q [2];

   logic              first_bit;
   logic              wr_last;
   logic              accept;
   logic              rd_active;
   logic              rd_last;
   logic [1:0]        cur_mod;
   logic [1:0]        cur_s;
   logic [1:0]        rd_mod;
   logic [ADDR_W-1:0] cur_n16;
   logic [ADDR_W-1:0] rd_n;
   logic [ADDR_W-1:0] wr_addr;
   logic [2:0]        frac_sum;
   logic [2:0]        frac;

   // floor(16*i/N) reduces to col, so j = i - (i mod s) + ((i - col) mod s).
   always_comb begin
      first_bit   = (col_q == 4'd0) && (row_q == '0);
      cur_mod     = first_bit ? MOD_SEL : mod_q;
      cur_s       = s_of(cur_mod);
      cur_n16     = n16_of(cur_mod);
      frac_sum    = 3'(rm_q) + 3'(cur_s) - 3'(cm_q);
      frac        = (frac_sum >= 3'(cur_s)) ? frac_sum - 3'(cur_s) : frac_sum;
      wr_addr     = idx_q - ADDR_W'(rm_q) + ADDR_W'(frac);
      wr_last     = (col_q == 4'd15) && (row_q == cur_n16 - ADDR_W'(1));
      rd_mod      = bank_mod_q[rd_ptr_q];
      rd_n        = ncbps_of(rd_mod);
      rd_active   = enable && full_q[rd_ptr_q];
      rd_last     = rd_active && (rd_addr_q == rd_n - ADDR_W'(1));
      // A bank draining its last bit this cycle may already take the next symbol's first bit.
      TX_IN_READY = !reset && (!full_q[wr_ptr_q] || (rd_last && (rd_ptr_q == wr_ptr_q)));
      accept      = enable && TX_IN_VALID && TX_IN_READY;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         col_q    <= '0;
         row_q    <= '0;
         idx_q    <= '0;
         rm_q     <= '0;
         cm_q     <= '0;
         mod_q    <= '0;
         wr_ptr_q <= 1'b0;
      end else if (accept) begin
         if (first_bit) begin
            mod_q <= MOD_SEL;
         end
         if (wr_last) begin
            col_q    <= '0;
            row_q    <= '0;
            idx_q    <= '0;
            rm_q     <= '0;
            cm_q     <= '0;
            wr_ptr_q <= ~wr_ptr_q;
         end else if (col_q == 4'd15) begin
            col_q <= '0;
            row_q <= row_q + ADDR_W'(1);
            idx_q <= row_q + ADDR_W'(1);
            cm_q  <= '0;
            rm_q  <= (rm_q + 2'd1 == cur_s) ? 2'd0 : rm_q + 2'd1;
         end else begin
            col_q <= col_q + 4'd1;
            idx_q <= idx_q + cur_n16;
            cm_q  <= (cm_q + 2'd1 == cur_s) ? 2'd0 : cm_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         bank_q[wr_ptr_q][wr_addr] <= inputData;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q        <= '0;
         bank_mod_q[0] <= '0;
         bank_mod_q[1] <= '0;
         rd_ptr_q      <= 1'b0;
         rd_addr_q     <= '0;
         TX_OUT        <= 1'b0;
         TX_OUT_VALID  <= 1'b0;
         SYM_DONE      <= 1'b0;
      end else begin
         if (accept && wr_last) begin
            full_q[wr_ptr_q]     <= 1'b1;
            bank_mod_q[wr_ptr_q] <= cur_mod;
         end
         if (rd_active) begin
            TX_OUT       <= bank_q[rd_ptr_q][rd_addr_q];
            TX_OUT_VALID <= 1'b1;
            SYM_DONE     <= rd_last;
            if (rd_last) begin
               full_q[rd_ptr_q] <= 1'b0;
               rd_ptr_q         <= ~rd_ptr_q;
               rd_addr_q        <= '0;
            end else begin
               rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
         end else begin
            TX_OUT_VALID <= 1'b0;
            SYM_DONE     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_phy_tx_interleaver.sv
// Bench for phy_tx_interleaver: arithmetic reference model feeding a scoreboard queue,
// popped by an output monitor, plus directed position/latency/flow checks.
module tb_phy_tx_interleaver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       inputData = 1'b0;
   logic       TX_IN_VALID = 1'b0;
   logic [1:0] MOD_SEL = 2'b00;
   logic       TX_IN_READY;
   logic       TX_OUT;
   logic       TX_OUT_VALID;
   logic       SYM_DONE;

   always #5 clock = ~clock;

   phy_tx_interleaver #(
      .MAX_NCBPS (288),
      .ADDR_W    (9)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .inputData    (inputData),
      .TX_IN_VALID  (TX_IN_VALID),
      .TX_IN_READY  (TX_IN_READY),
      .MOD_SEL      (MOD_SEL),
      .TX_OUT       (TX_OUT),
      .TX_OUT_VALID (TX_OUT_VALID),
      .SYM_DONE     (SYM_DONE)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] exp_q [$];
   int         mk = 0;
   logic [1:0] mmod = 2'b00;
   bit         in_bits [288];
   int         pos = 0;
   int         one_pos = -1;
   int         last_one_pos = -1;
   int         cur_run = 0;
   int         max_run = 0;

   function automatic int ncbps_of(input logic [1:0] m);
      case (m)
         2'b00:   return 48;
         2'b01:   return 96;
         2'b10:   return 192;
         default: return 288;
      endcase
   endfunction

   function automatic int bpsc_of(input logic [1:0] m);
      case (m)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 6;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Both permutations straight from the standard's formulas.
   function automatic void push_symbol();
      int n;
      int s;
      bit o [288];
      n = ncbps_of(mmod);
      s = (bpsc_of(mmod) / 2 > 1) ? bpsc_of(mmod) / 2 : 1;
      for (int k = 0; k < n; k++) begin
         int i;
         int j;
         i = (n / 16) * (k % 16) + k / 16;
         j = s * (i / s) + ((i + n - (16 * i) / n) % s);
         o[j] = in_bits[k];
      end
      for (int p = 0; p < n; p++) exp_q.push_back({o[p], (p == n - 1) ? 1'b1 : 1'b0});
   endfunction

   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         mk = 0;
         pos = 0;
         one_pos = -1;
         cur_run = 0;
      end else begin
         if (TX_OUT_VALID) begin
            logic [1:0] e;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_bit_and_done", int'({TX_OUT, SYM_DONE}), int'(e));
            end
            if (TX_OUT === 1'b1) one_pos = pos;
            pos++;
            if (SYM_DONE) begin
               last_one_pos = one_pos;
               one_pos = -1;
               pos = 0;
            end
         end else begin
            cur_run = 0;
            if (SYM_DONE) check("sym_done_without_valid", 1, 0);
         end
         if (enable && TX_IN_VALID && TX_IN_READY) begin
            if (mk == 0) mmod = MOD_SEL;
            in_bits[mk] = inputData;
            mk++;
            if (mk == ncbps_of(mmod)) begin
               push_symbol();
               mk = 0;
            end
         end
      end
   end

   // hot < 0: random data; gaps: random valid and enable dropouts.
   task automatic send_bits(input int n, input logic [1:0] mod_a, input logic [1:0] mod_b,
                            input int switch_k, input int hot, input bit gaps);
      int k = 0;
      int budget = 20000;
      bit acc;
      while (k < n) begin
         MOD_SEL     = (k < switch_k) ? mod_a : mod_b;
         inputData   = (hot < 0) ? 1'($urandom) : ((k == hot) ? 1'b1 : 1'b0);
         TX_IN_VALID = gaps ? ($urandom_range(3) != 0) : 1'b1;
         if (gaps) enable = ($urandom_range(7) != 0);
         @(negedge clock);
         acc = enable && TX_IN_VALID && TX_IN_READY;
         @(posedge clock);
         #1;
         if (acc) k++;
         budget--;
         if (budget == 0) begin
            check("send_timeout", k, n);
            break;
         end
      end
      enable = 1'b1;
   endtask

   task automatic send_sym(input logic [1:0] m, input int hot);
      send_bits(ncbps_of(m), m, m, 1 << 30, hot, 1'b0);
   endtask

   task automatic wait_idle();
      int t = 0;
      TX_IN_VALID = 1'b0;
      while ((exp_q.size() != 0 || mk != 0 || TX_OUT_VALID) && t < 3000) begin
         @(posedge clock);
         #1;
         t++;
      end
      check("drain_in_time", (t < 3000) ? 1 : 0, 1);
   endtask

   initial begin
      #2000000;
      n_err++;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int hots [4];
      int exps [4];
      int gaps;
      logic [1:0] m;
      hots = '{1, 16, 17, 0};
      exps = '{20, 1, 18, 0};

      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_tx_out", TX_OUT, 0);
      check("rst_valid", TX_OUT_VALID, 0);
      check("rst_sym_done", SYM_DONE, 0);
      check("rst_ready", TX_IN_READY, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      enable = 1'b1;
      @(negedge clock);
      check("ready_after_reset", TX_IN_READY, 1);
      @(posedge clock);
      #1;

      // BPSK one-hot at k=1 with latency check.
      send_sym(2'b00, 1);
      TX_IN_VALID = 1'b0;
      @(negedge clock);
      check("latency_cycle1_valid", TX_OUT_VALID, 0);
      @(negedge clock);
      check("latency_cycle2_valid", TX_OUT_VALID, 1);
      wait_idle();
      check("bpsk_k1_pos", last_one_pos, 3);

      for (int h = 0; h < 4; h++) begin
         send_sym(2'b11, hots[h]);
         wait_idle();
         check("qam64_onehot_pos", last_one_pos, exps[h]);
      end

      send_sym(2'b10, 1);
      wait_idle();
      check("qam16_k1_pos", last_one_pos, 13);

      // Three back-to-back 16-QAM symbols.
      max_run = 0;
      for (int r = 0; r < 3; r++) send_sym(2'b10, -1);
      wait_idle();
      check("b2b_valid_run", max_run, 576);

      // MOD_SEL switches to 64-QAM at k=20 of a BPSK symbol.
      send_bits(48, 2'b00, 2'b11, 20, -1, 1'b0);
      send_sym(2'b11, -1);
      wait_idle();

      // Both banks full, then enable low for 5 cycles mid-read.
      send_sym(2'b11, -1);
      send_sym(2'b00, -1);
      TX_IN_VALID = 1'b0;
      @(negedge clock);
      check("ready_both_full", TX_IN_READY, 0);
      @(posedge clock);
      #1;
      gaps = 0;
      enable = 1'b0;
      repeat (5) begin
         @(negedge clock);
         if (!TX_OUT_VALID) gaps++;
         @(posedge clock);
         #1;
      end
      enable = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (!TX_OUT_VALID) gaps++;
         @(posedge clock);
         #1;
      end
      check("enable_valid_gap", gaps, 5);
      wait_idle();

      // Reset with a read active and a 64-QAM symbol at k=100.
      send_sym(2'b11, -1);
      send_bits(100, 2'b11, 2'b11, 1 << 30, -1, 1'b0);
      TX_IN_VALID = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("midrst_tx_out", TX_OUT, 0);
      check("midrst_valid", TX_OUT_VALID, 0);
      check("midrst_sym_done", SYM_DONE, 0);
      check("midrst_ready", TX_IN_READY, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      send_sym(2'b00, 5);
      wait_idle();
      check("post_reset_bpsk_pos", last_one_pos, 15);

      // Random modes with input gaps and enable dropouts.
      for (int r = 0; r < 6; r++) begin
         m = 2'($urandom_range(3));
         send_bits(ncbps_of(m), m, m, 1 << 30, -1, 1'b1);
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
